sign_exp_mul_pipe: RTL and testbench
====================================

SIGN_EXP_MUL_PIPE -- requirements
Module: sign_exp_mul_pipe

Interface
REQ-001 Parameter: EXP_W, default 11, exponent field width.
REQ-002 Parameter: SHFT_W, default 8, alignment shift-amount width.
REQ-003 Parameter: BIAS_D / BIAS_S / BIAS_H, defaults 1022 / 126 / 14, product bias minus one per precision.
REQ-004 Ports: clk  in  1  clock; rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
REQ-005 Ports: in_valid  in  1  operand valid; in_ready  out  1  operand accepted when in_valid&in_ready.
REQ-006 Ports: a_cls, b_cls  in  4 each  class {is_zero,is_norm,is_inf,is_nan}; a_sign, b_sign  in  1 each; a_exp, b_exp, c_exp  in  EXP_W each.
REQ-007 Ports: precision  in  2  11 double, 10 single, 01 half, 00 treated as double; mode  in  2  alignment offset select; is_mul  in  1  multiply (else pass-through of a).
REQ-008 Ports: out_valid  out  1; out_ready  in  1; out_sign  out  1; out_exp  out  EXP_W+2  signed result exponent.
REQ-009 Ports: out_flags  out  5  {underflow,overflow,inf,nan,zero}; shft_amt  out  SHFT_W; is_shft  out  1; is_sat  out  1.
REQ-010 Ports: sticky_flags  out  5  accumulated out_flags; clr_flags  in  1  sticky clear.

Function
REQ-011 Two-stage pipeline: S1 registers sign, classification result and raw exponent; S2 registers exponent-difference, shift and flag outputs.
REQ-012 Latency exactly 2 cycles from accepted input to out_valid when out_ready held high; throughput 1 per cycle.
REQ-013 in_ready = !S1_valid | S1 advances; S1 advances when !S2_valid | out_ready; no operand dropped or duplicated under any out_ready pattern.
REQ-014 S2 outputs held stable while out_valid & !out_ready.
REQ-015 Sign: is_mul ? a_sign^b_sign : a_sign.
REQ-016 Classification priority: a zero (nan if is_mul & b inf/nan, else zero) > b zero & is_mul (nan if a inf/nan) > a or (b & is_mul) not normal -> zero (flush) > inf/nan on a or (b & is_mul) -> nan if any nan else inf > normal arithmetic.
REQ-017 Zero class: out_exp = 0; inf/nan class: out_exp = all ones.
REQ-018 Normal: sum = is_mul ? a_exp+b_exp-bias(precision) : a_exp, computed signed in EXP_W+2 bits, no truncation.
REQ-019 Overflow when sum >= 30 (half), 254 (single), 2046 (double/00); sets overflow and inf, out_exp = all ones.
REQ-020 Underflow when sum < 0; sets underflow only, out_exp = 0.
REQ-021 expdiff = out_exp - c_exp signed; shift = expdiff + (mode==01 ? 11 : mode==10 ? 24 : 53).
REQ-022 is_sat = shift > 2^SHFT_W-1 (signed compare); shft_amt = is_sat ? all ones : shift[SHFT_W-1:0]; negative shift not saturated, low bits passed.
REQ-023 is_shft = signed out_exp >= c_exp.
REQ-024 sticky_flags |= out_flags on each out_valid&out_ready; clr_flags alone zeroes it next cycle; clr_flags with a transfer in the same cycle loads that transfer's flags only.

Reset
REQ-025 On rst_n low, immediately: S1/S2 valid = 0, out_valid = 0, all data outputs = 0, sticky_flags = 0, in_ready = 1.
REQ-026 Reset mid-operation discards all in-flight operands; first post-reset output comes only from operands accepted after release.

Verification
REQ-027 Double, a_exp=b_exp=1023, c_exp=1024, mode=11, is_mul=1 -> after 2 cycles out_exp=1024, shft_amt=53, is_shft=1, flags=0.
REQ-028 Half, a_exp=b_exp=30 -> sum 46 >= 30: overflow=1, inf=1, out_exp=all ones; sticky_flags overflow bit set.
REQ-029 a_cls zero, b_cls inf, is_mul=1 -> nan=1, zero=0; same with is_mul=0 -> zero=1.
REQ-030 Single, a_exp=b_exp=10 -> sum -106: underflow=1, out_exp=0, c_exp=200 gives negative shift, is_sat=0, is_shft=0.
REQ-031 Stream 6 operands with out_ready toggling 1,0,0,1,0,1 -> all 6 outputs in order, in_ready low while both stages full and stalled.
REQ-032 Assert rst_n low with 2 operands in flight -> out_valid=0 immediately, sticky_flags=0, no stale output after release.

Source files
------------

// File: rtl/sign_exp_mul_pipe.sv
// sign_exp_mul_pipe -- two-stage exponent/sign datapath for a floating-point
// multiply (or pass-through of operand a) feeding an addend alignment step.
//
// Stage 1 resolves the result sign, the operand classes and the biased
// product exponent (with overflow/underflow detection). Stage 2 forms the
// exponent difference against the addend exponent c_exp and from it the
// alignment shift amount. Valid/ready handshake on both sides.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake
//   a_cls, b_cls        class {is_zero,is_norm,is_inf,is_nan}
//   a_sign, b_sign      operand signs
//   a_exp, b_exp, c_exp biased exponents
//   precision           11 double, 10 single, 01 half, 00 double
//   mode                alignment offset select (01:11, 10:24, else 53)
//   is_mul              1 = multiply a*b, 0 = pass a through
//   out_valid/out_ready result handshake
//   out_sign, out_exp   result sign and signed result exponent
//   out_flags           {underflow,overflow,inf,nan,zero}
//   shft_amt, is_shft, is_sat  alignment shift, out_exp>=c_exp, saturation
//   sticky_flags        OR of out_flags over accepted results
//   clr_flags           clears sticky_flags
module sign_exp_mul_pipe #(
  parameter int EXP_W  = 11,
  parameter int SHFT_W = 8,
  parameter int BIAS_D = 1022,
  parameter int BIAS_S = 126,
  parameter int BIAS_H = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          a_cls,
  input  logic [3:0]          b_cls,
  input  logic                a_sign,
  input  logic                b_sign,
  input  logic [EXP_W-1:0]    a_exp,
  input  logic [EXP_W-1:0]    b_exp,
  input  logic [EXP_W-1:0]    c_exp,
  input  logic [1:0]          precision,
  input  logic [1:0]          mode,
  input  logic                is_mul,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sign,
  output logic [EXP_W+1:0]    out_exp,
  output logic [4:0]          out_flags,
  output logic [SHFT_W-1:0]   shft_amt,
  output logic                is_shft,
  output logic                is_sat,
  output logic [4:0]          sticky_flags,
  input  logic                clr_flags
);

  localparam int OW = EXP_W + 2;  // signed result exponent width
  localparam int SW = EXP_W + 3;  // signed shift arithmetic width

  localparam logic [4:0] FLG_ZERO = 5'b00001;
  localparam logic [4:0] FLG_NAN  = 5'b00010;
  localparam logic [4:0] FLG_INF  = 5'b00100;
  localparam logic [4:0] FLG_OVF  = 5'b01000;
  localparam logic [4:0] FLG_UF   = 5'b10000;

  // Inf/nan/overflow results carry an all-ones exponent across the full
  // signed field (reads as -1 when interpreted signed).
  localparam logic [OW-1:0] EXP_ONES = {OW{1'b1}};

  // Stage 1 registers
  logic                s1_valid_r;
  logic                s1_sign_r;
  logic [4:0]          s1_flags_r;
  logic signed [OW-1:0] s1_exp_r;
  logic [EXP_W-1:0]    s1_c_exp_r;
  logic [1:0]          s1_mode_r;

  // Stage 2 / output registers
  logic                s2_valid_r;
  logic                out_sign_r;
  logic [OW-1:0]       out_exp_r;
  logic [4:0]          out_flags_r;
  logic [SHFT_W-1:0]   shft_amt_r;
  logic                is_shft_r;
  logic                is_sat_r;
  logic [4:0]          sticky_r;

  logic                s1_adv_s;
  logic                xfer_s;

  // Class decode; "sub" = none of the recognised classes (flushed to zero).
  logic a_zero_s, a_nan_s, a_spec_s, a_sub_s;
  logic b_zero_s, b_nan_s, b_spec_s, b_sub_s;

  logic signed [OW-1:0] bias_s;
  logic signed [OW-1:0] lim_s;
  logic signed [OW-1:0] sum_s;
  logic signed [OW-1:0] s1_exp_s;
  logic [4:0]           s1_flags_s;
  logic                 s1_sign_s;

  logic signed [SW-1:0] expdiff_s;
  logic signed [SW-1:0] off_s;
  logic signed [SW-1:0] shift_s;
  logic                 is_sat_s;
  logic [SHFT_W-1:0]    shft_s;

  assign s1_adv_s = !s2_valid_r || out_ready;
  assign in_ready = !s1_valid_r || s1_adv_s;
  assign xfer_s   = s2_valid_r && out_ready;

  assign a_zero_s = a_cls[3];
  assign a_nan_s  = a_cls[0];
  assign a_spec_s = a_cls[1] || a_cls[0];
  assign a_sub_s  = !(a_cls[2] || a_cls[1] || a_cls[0]);
  assign b_zero_s = b_cls[3];
  assign b_nan_s  = b_cls[0];
  assign b_spec_s = b_cls[1] || b_cls[0];
  assign b_sub_s  = !(b_cls[2] || b_cls[1] || b_cls[0]);

  assign s1_sign_s = is_mul ? (a_sign ^ b_sign) : a_sign;

  // Product bias and overflow limit per precision.
  always_comb begin
    bias_s = OW'(BIAS_D);
    lim_s  = OW'(2046);
    case (precision)
      2'b10: begin
        bias_s = OW'(BIAS_S);
        lim_s  = OW'(254);
      end
      2'b01: begin
        bias_s = OW'(BIAS_H);
        lim_s  = OW'(30);
      end
      default: begin
        bias_s = OW'(BIAS_D);
        lim_s  = OW'(2046);
      end
    endcase
  end

  // Full-width signed exponent sum; cannot wrap inside OW bits.
  assign sum_s = is_mul ? ($signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - bias_s)
                        : $signed({2'b00, a_exp});

  // Classification in priority order, then range checks on the sum.
  always_comb begin
    s1_flags_s = 5'b00000;
    s1_exp_s   = '0;
    if (a_zero_s) begin
      if (is_mul && b_spec_s) begin
        s1_flags_s = FLG_NAN;
        s1_exp_s   = EXP_ONES;
      end else begin
        s1_flags_s = FLG_ZERO;
      end
    end else if (is_mul && b_zero_s) begin
      if (a_spec_s) begin
        s1_flags_s = FLG_NAN;
        s1_exp_s   = EXP_ONES;
      end else begin
        s1_flags_s = FLG_ZERO;
      end
    end else if (a_sub_s || (is_mul && b_sub_s)) begin
      s1_flags_s = FLG_ZERO;
    end else if (a_spec_s || (is_mul && b_spec_s)) begin
      s1_exp_s = EXP_ONES;
      if (a_nan_s || (is_mul && b_nan_s)) begin
        s1_flags_s = FLG_NAN;
      end else begin
        s1_flags_s = FLG_INF;
      end
    end else if (sum_s >= lim_s) begin
      s1_flags_s = FLG_OVF | FLG_INF;
      s1_exp_s   = EXP_ONES;
    end else if (sum_s[OW-1]) begin
      s1_flags_s = FLG_UF;
    end else begin
      s1_exp_s = sum_s;
    end
  end

  // Alignment offset by mode.
  always_comb begin
    off_s = SW'(53);
    case (s1_mode_r)
      2'b01:   off_s = SW'(11);
      2'b10:   off_s = SW'(24);
      default: off_s = SW'(53);
    endcase
  end

  assign expdiff_s = $signed({s1_exp_r[OW-1], s1_exp_r}) - $signed({3'b000, s1_c_exp_r});
  assign shift_s   = expdiff_s + off_s;
  assign is_sat_s  = shift_s > $signed(SW'((2 ** SHFT_W) - 1));
  // Negative shifts are not saturated; their low bits pass through.
  assign shft_s    = is_sat_s ? {SHFT_W{1'b1}} : shift_s[SHFT_W-1:0];

  // Stage 1 register: loads whenever the stage can accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_sign_r  <= 1'b0;
      s1_flags_r <= 5'b00000;
      s1_exp_r   <= '0;
      s1_c_exp_r <= '0;
      s1_mode_r  <= 2'b00;
    end else if (in_ready) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_sign_r  <= s1_sign_s;
        s1_flags_r <= s1_flags_s;
        s1_exp_r   <= s1_exp_s;
        s1_c_exp_r <= c_exp;
        s1_mode_r  <= mode;
      end
    end
  end

  // Stage 2 / output register: holds while stalled downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r  <= 1'b0;
      out_sign_r  <= 1'b0;
      out_exp_r   <= '0;
      out_flags_r <= 5'b00000;
      shft_amt_r  <= '0;
      is_shft_r   <= 1'b0;
      is_sat_r    <= 1'b0;
    end else if (s1_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_sign_r  <= s1_sign_r;
        out_exp_r   <= s1_exp_r;
        out_flags_r <= s1_flags_r;
        shft_amt_r  <= shft_s;
        is_shft_r   <= !expdiff_s[SW-1];
        is_sat_r    <= is_sat_s;
      end
    end
  end

  // Sticky flags: clear wins over history but not over the current transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_r <= 5'b00000;
    end else if (xfer_s) begin
      sticky_r <= clr_flags ? out_flags_r : (sticky_r | out_flags_r);
    end else if (clr_flags) begin
      sticky_r <= 5'b00000;
    end
  end

  assign out_valid    = s2_valid_r;
  assign out_sign     = out_sign_r;
  assign out_exp      = out_exp_r;
  assign out_flags    = out_flags_r;
  assign shft_amt     = shft_amt_r;
  assign is_shft      = is_shft_r;
  assign is_sat       = is_sat_r;
  assign sticky_flags = sticky_r;

endmodule

// File: tb/tb_sign_exp_mul_pipe.sv
module tb_sign_exp_mul_pipe;
  localparam int EXP_W = 11;
  localparam int SHFT_W = 8;
  localparam int OW = EXP_W + 2;

  localparam logic [3:0] C_ZERO = 4'b1000;
  localparam logic [3:0] C_NORM = 4'b0100;
  localparam logic [3:0] C_INF  = 4'b0010;
  localparam logic [3:0] C_NAN  = 4'b0001;
  localparam logic [3:0] C_SUB  = 4'b0000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [3:0] a_cls = 4'b0100, b_cls = 4'b0100;
  logic a_sign = 1'b0, b_sign = 1'b0;
  logic [EXP_W-1:0] a_exp = '0, b_exp = '0, c_exp = '0;
  logic [1:0] precision = 2'b11, mode = 2'b11;
  logic is_mul = 1'b1;
  logic out_valid, out_ready;
  logic out_sign;
  logic [EXP_W+1:0] out_exp;
  logic [4:0] out_flags, sticky_flags;
  logic [SHFT_W-1:0] shft_amt;
  logic is_shft, is_sat;
  logic clr_flags = 1'b0;

  sign_exp_mul_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_cls(a_cls), .b_cls(b_cls), .a_sign(a_sign), .b_sign(b_sign),
    .a_exp(a_exp), .b_exp(b_exp), .c_exp(c_exp), .precision(precision),
    .mode(mode), .is_mul(is_mul), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_flags(out_flags),
    .shft_amt(shft_amt), .is_shft(is_shft), .is_sat(is_sat),
    .sticky_flags(sticky_flags), .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          sign;
    logic [4:0]    flags;
    logic [OW-1:0] oexp;
    logic [7:0]    shft;
    logic          shf;
    logic          sat;
    int            acc_cyc;
    bit            nostall;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int pidx = 0;
  logic [4:0] sticky_m = 5'b00000;
  bit rst_seen = 0;
  bit held = 0;
  logic [28:0] held_v;
  logic [5:0] pat = 6'b101001;  // bit i = out_ready in pattern step i: 1,0,0,1,0,1

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference: the classification/exponent rules written with plain integers.
  function automatic exp_t model(input logic [3:0] ac, input logic [3:0] bc,
                                 input logic as, input logic bs, input int ae,
                                 input int be, input int ce, input logic [1:0] pr,
                                 input logic [1:0] md, input logic mul);
    exp_t r;
    bit az = ac[3], an = ac[0], aspec = ac[1] | ac[0], asub = (ac == 4'b0000);
    bit bz = bc[3], bn = bc[0], bspec = bc[1] | bc[0], bsub = (bc == 4'b0000);
    int bias, lim, oe, sum, off, sh;
    logic [4:0] fl;
    bias = (pr == 2'b10) ? 126 : (pr == 2'b01) ? 14 : 1022;
    lim  = (pr == 2'b10) ? 254 : (pr == 2'b01) ? 30 : 2046;
    sum  = mul ? ae + be - bias : ae;
    oe = 0;
    fl = 5'b00000;
    if (az) begin
      if (mul && bspec) begin fl = 5'b00010; oe = -1; end
      else fl = 5'b00001;
    end else if (mul && bz) begin
      if (aspec) begin fl = 5'b00010; oe = -1; end
      else fl = 5'b00001;
    end else if (asub || (mul && bsub)) begin
      fl = 5'b00001;
    end else if (aspec || (mul && bspec)) begin
      oe = -1;
      fl = (an || (mul && bn)) ? 5'b00010 : 5'b00100;
    end else if (sum >= lim) begin
      fl = 5'b01100; oe = -1;
    end else if (sum < 0) begin
      fl = 5'b10000; oe = 0;
    end else begin
      oe = sum;
    end
    off = (md == 2'b01) ? 11 : (md == 2'b10) ? 24 : 53;
    sh = oe - ce + off;
    r.sign = mul ? (as ^ bs) : as;
    r.flags = fl;
    r.oexp = OW'(oe);
    r.sat = (sh > 255);
    r.shft = r.sat ? 8'hFF : 8'(sh & 255);
    r.shf = (oe >= ce);
    r.acc_cyc = 0;
    r.nostall = 0;
    return r;
  endfunction

  // Cycle counter for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready generator.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin out_ready = pat[pidx % 6]; pidx++; end
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor / scoreboard: samples on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic [4:0] xf;
    bit xfer;
    if (!rst_n) begin
      if (!rst_seen) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sticky", sticky_flags, 0);
        chk("rst_out_exp", out_exp, 0);
        chk("rst_out_flags", out_flags, 0);
        chk("rst_shft_amt", shft_amt, 0);
        rst_seen = 1;
      end
      sb.delete();
      sticky_m = 5'b00000;
      held = 0;
    end else begin
      rst_seen = 0;
      chk("in_ready", in_ready, (sb.size() < 2) || out_ready);
      if (held)
        chk("stall_hold", {out_sign, out_exp, out_flags, shft_amt, is_shft, is_sat}, held_v);
      xfer = 0;
      xf = 5'b00000;
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_out", out_valid, 0);
        end else if (out_ready) begin
          e = sb.pop_front();
          xfer = 1;
          xf = e.flags;
          chk("out_sign", out_sign, e.sign);
          chk("out_exp", out_exp, e.oexp);
          chk("out_flags", out_flags, e.flags);
          chk("shft_amt", shft_amt, e.shft);
          chk("is_shft", is_shft, e.shf);
          chk("is_sat", is_sat, e.sat);
          if (e.nostall && rdy_mode == 0) chk("latency", cyc - e.acc_cyc, 2);
        end
      end
      held = out_valid && !out_ready;
      held_v = {out_sign, out_exp, out_flags, shft_amt, is_shft, is_sat};
      chk("sticky", sticky_flags, sticky_m);
      if (clr_flags) sticky_m = xfer ? xf : 5'b00000;
      else if (xfer) sticky_m = sticky_m | xf;
      if (in_valid && in_ready) begin
        e = model(a_cls, b_cls, a_sign, b_sign, int'(a_exp), int'(b_exp), int'(c_exp),
                  precision, mode, is_mul);
        e.acc_cyc = cyc;
        e.nostall = (rdy_mode == 0);
        sb.push_back(e);
      end
    end
  end

  task automatic send(input logic [3:0] ac, input logic [3:0] bc, input logic as,
                      input logic bs, input int ae, input int be, input int ce,
                      input logic [1:0] pr, input logic [1:0] md, input logic mul);
    int w;
    a_cls = ac; b_cls = bc; a_sign = as; b_sign = bs;
    a_exp = EXP_W'(ae); b_exp = EXP_W'(be); c_exp = EXP_W'(ce);
    precision = pr; mode = md; is_mul = mul;
    in_valid = 1'b1;
    w = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 50) begin
        chk("accept_timeout", in_ready, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || out_valid) && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  logic [3:0] cls_tab [5] = '{C_NORM, C_ZERO, C_INF, C_NAN, C_SUB};

  function automatic logic [3:0] rand_cls();
    int k;
    k = $urandom_range(0, 9);
    return (k < 6) ? C_NORM : cls_tab[k - 5];
  endfunction

  initial begin
    logic [1:0] pr;
    int hi;
    #2 rst_n = 1'b0;
    #1 chk("rst_async_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Double multiply, basic alignment.
    send(C_NORM, C_NORM, 1'b0, 1'b1, 1023, 1023, 1024, 2'b11, 2'b11, 1'b1);
    drain();
    // Half overflow, then sticky overflow bit.
    send(C_NORM, C_NORM, 1'b1, 1'b1, 30, 30, 0, 2'b01, 2'b11, 1'b1);
    drain();
    chk("sticky_ovf_bit", sticky_flags[3], 1);
    // Half overflow boundary: 29 stays normal, 30 overflows.
    send(C_NORM, C_NORM, 1'b0, 1'b0, 21, 22, 5, 2'b01, 2'b01, 1'b1);
    send(C_NORM, C_NORM, 1'b0, 1'b0, 22, 22, 5, 2'b01, 2'b01, 1'b1);
    // Zero times inf is nan; pass-through of zero stays zero.
    send(C_ZERO, C_INF, 1'b0, 1'b0, 0, 2047, 3, 2'b11, 2'b11, 1'b1);
    send(C_ZERO, C_INF, 1'b1, 1'b0, 0, 2047, 3, 2'b11, 2'b11, 1'b0);
    // Single underflow with negative shift.
    send(C_NORM, C_NORM, 1'b0, 1'b1, 10, 10, 200, 2'b10, 2'b11, 1'b1);
    // Saturation boundary: shift 255 then 256.
    send(C_NORM, C_NORM, 1'b0, 1'b0, 202, 0, 0, 2'b00, 2'b11, 1'b0);
    send(C_NORM, C_NORM, 1'b0, 1'b0, 203, 0, 0, 2'b00, 2'b11, 1'b0);
    // Flush, inf*norm, nan, b zero times inf.
    send(C_SUB, C_NORM, 1'b0, 1'b0, 5, 900, 10, 2'b11, 2'b10, 1'b1);
    send(C_INF, C_NORM, 1'b1, 1'b0, 5, 900, 10, 2'b11, 2'b10, 1'b1);
    send(C_INF, C_NAN, 1'b1, 1'b1, 5, 900, 10, 2'b11, 2'b01, 1'b1);
    send(C_INF, C_ZERO, 1'b0, 1'b1, 5, 0, 10, 2'b11, 2'b01, 1'b1);
    drain();
    // Clear sticky with no transfer.
    clr_flags = 1'b1;
    @(posedge clk);
    #1 clr_flags = 1'b0;
    @(negedge clk);
    chk("sticky_cleared", sticky_flags, 0);

    // Stream six operands under the 1,0,0,1,0,1 ready pattern.
    @(posedge clk);
    #1;
    pidx = 0;
    rdy_mode = 2;
    for (int i = 0; i < 6; i++)
      send(C_NORM, C_NORM, 1'(i), 1'b0, 1000 + i, 1020, 1000, 2'b11, 2'(i % 4), 1'b1);
    drain();

    // Randomized phase with random backpressure and sticky clears.
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      pr = 2'($urandom_range(0, 3));
      hi = (pr == 2'b01) ? 31 : (pr == 2'b10) ? 255 : 2047;
      clr_flags = ($urandom_range(0, 7) == 0);
      send(rand_cls(), rand_cls(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, hi), $urandom_range(0, hi),
           ($urandom_range(0, 1) == 1) ? $urandom_range(0, 2047) : $urandom_range(0, hi),
           pr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0));
      clr_flags = 1'b0;
    end
    rdy_mode = 0;
    drain();

    // Reset with two operands in flight.
    send(C_NORM, C_NORM, 1'b0, 1'b0, 30, 30, 1, 2'b01, 2'b11, 1'b1);
    send(C_NORM, C_NORM, 1'b0, 1'b0, 1100, 1100, 1, 2'b11, 2'b11, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_sticky", sticky_flags, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send(C_NORM, C_NORM, 1'b1, 1'b0, 100, 1000, 50, 2'b11, 2'b10, 1'b1);
    send(C_NAN, C_NORM, 1'b0, 1'b0, 100, 1000, 50, 2'b11, 2'b10, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
